// File: rtl/accel_sample_filter.sv
// Per-axis moving-average filter for X/Y/Z accelerometer samples with tilt
// detection, a priming indicator and a sticky overrun flag.
module accel_sample_filter #(
  parameter int          LOG2_DEPTH  = 3,
  parameter logic [15:0] TILT_THRESH = 16'd64
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic [15:0] AccelX,
  input  logic [15:0] AccelY,
  input  logic [15:0] AccelZ,
  input  logic        SAMPLE_VALID,
  input  logic        CLEAR,
  output logic [15:0] FILT_X,
  output logic [15:0] FILT_Y,
  output logic [15:0] FILT_Z,
  output logic        FILT_VALID,
  output logic        TILT_X,
  output logic        TILT_Y,
  output logic        TILT_Z,
  output logic        PRIMED,
  output logic        OVERRUN
);

  localparam int                  DEPTH     = 1 << LOG2_DEPTH;
  localparam int                  SW        = 16 + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] FILL_FULL = {1'b1, {LOG2_DEPTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_e;

  state_e state_q, state_d;

  logic signed [15:0]     accel_in [3];
  logic signed [15:0]     smp_q    [3];
  logic signed [15:0]     smp_d    [3];
  logic signed [15:0]     buf_q    [3][DEPTH];
  logic signed [15:0]     buf_d    [3][DEPTH];
  logic signed [SW-1:0]   sum_q    [3];
  logic signed [SW-1:0]   sum_d    [3];
  logic signed [15:0]     filt_q   [3];
  logic signed [15:0]     filt_d   [3];
  logic signed [15:0]     avg      [3];
  logic [16:0]            ext      [3];
  logic [16:0]            mag      [3];
  logic [2:0]             over_thresh;
  logic [2:0]             tilt_q, tilt_d;
  logic [LOG2_DEPTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH:0]    fill_q, fill_d;
  logic                   filt_valid_q, filt_valid_d;
  logic                   primed_q, primed_d;
  logic                   overrun_q, overrun_d;

  assign accel_in[0] = AccelX;
  assign accel_in[1] = AccelY;
  assign accel_in[2] = AccelZ;

  // Average is the top 16 bits of the sum: an arithmetic shift that floors.
  // Magnitude is taken in 17 bits so -32768 maps to +32768 without wrapping.
  always_comb begin
    for (int a = 0; a < 3; a++) begin
      avg[a]         = sum_q[a][SW-1:LOG2_DEPTH];
      ext[a]         = {avg[a][15], avg[a]};
      mag[a]         = ext[a][16] ? (~ext[a] + 17'd1) : ext[a];
      over_thresh[a] = mag[a] > {1'b0, TILT_THRESH};
    end
  end

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (CLEAR) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (SAMPLE_VALID) state_d = ACC;
        ACC:     state_d = OUT;
        OUT:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    smp_d        = smp_q;
    buf_d        = buf_q;
    sum_d        = sum_q;
    filt_d       = filt_q;
    tilt_d       = tilt_q;
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    primed_d     = primed_q;
    overrun_d    = overrun_q;
    filt_valid_d = 1'b0;
    if (CLEAR) begin
      buf_d     = '{default: '0};
      sum_d     = '{default: '0};
      filt_d    = '{default: '0};
      tilt_d    = '0;
      wr_ptr_d  = '0;
      fill_d    = '0;
      primed_d  = 1'b0;
      overrun_d = 1'b0;
    end else begin
      if (SAMPLE_VALID && state_q != IDLE) overrun_d = 1'b1;
      case (state_q)
        IDLE: if (SAMPLE_VALID) smp_d = accel_in;
        ACC: begin
          // Modular arithmetic: the transient sum+new may exceed the width,
          // but the final windowed sum always fits.
          for (int a = 0; a < 3; a++) begin
            sum_d[a]           = sum_q[a] + SW'(smp_q[a]) - SW'(buf_q[a][wr_ptr_q]);
            buf_d[a][wr_ptr_q] = smp_q[a];
          end
          wr_ptr_d = wr_ptr_q + (LOG2_DEPTH)'(1);
          if (fill_q != FILL_FULL) fill_d = fill_q + (LOG2_DEPTH+1)'(1);
        end
        OUT: begin
          if (fill_q == FILL_FULL) begin
            filt_d       = avg;
            tilt_d       = over_thresh;
            filt_valid_d = 1'b1;
            primed_d     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the window buffer is in the reset because a reset must leave every
  // entry zero; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      smp_q        <= '{default: '0};
      buf_q        <= '{default: '0};
      sum_q        <= '{default: '0};
      filt_q       <= '{default: '0};
      tilt_q       <= '0;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      filt_valid_q <= 1'b0;
      primed_q     <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q      <= state_d;
      smp_q        <= smp_d;
      buf_q        <= buf_d;
      sum_q        <= sum_d;
      filt_q       <= filt_d;
      tilt_q       <= tilt_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      filt_valid_q <= filt_valid_d;
      primed_q     <= primed_d;
      overrun_q    <= overrun_d;
    end
  end

  assign FILT_X     = filt_q[0];
  assign FILT_Y     = filt_q[1];
  assign FILT_Z     = filt_q[2];
  assign TILT_X     = tilt_q[0];
  assign TILT_Y     = tilt_q[1];
  assign TILT_Z     = tilt_q[2];
  assign FILT_VALID = filt_valid_q;
  assign PRIMED     = primed_q;
  assign OVERRUN    = overrun_q;

endmodule

// File: tb/tb_accel_sample_filter.sv
// Scoreboard bench for accel_sample_filter: a behavioural window model queues
// expected outputs per sample; a negedge monitor pops and compares them.
module tb_accel_sample_filter;

  logic               CLOCK_50 = 1'b0;
  logic               RESET;
  logic signed [15:0] AccelX, AccelY, AccelZ;
  logic               SAMPLE_VALID, CLEAR;
  logic signed [15:0] FILT_X, FILT_Y, FILT_Z;
  logic               FILT_VALID, TILT_X, TILT_Y, TILT_Z, PRIMED, OVERRUN;

  accel_sample_filter #(.LOG2_DEPTH(3), .TILT_THRESH(16'd64)) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET       (RESET),
    .AccelX      (AccelX),
    .AccelY      (AccelY),
    .AccelZ      (AccelZ),
    .SAMPLE_VALID(SAMPLE_VALID),
    .CLEAR       (CLEAR),
    .FILT_X      (FILT_X),
    .FILT_Y      (FILT_Y),
    .FILT_Z      (FILT_Z),
    .FILT_VALID  (FILT_VALID),
    .TILT_X      (TILT_X),
    .TILT_Y      (TILT_Y),
    .TILT_Z      (TILT_Z),
    .PRIMED      (PRIMED),
    .OVERRUN     (OVERRUN)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic signed [15:0] fx, fy, fz;
    logic               tx, ty, tz;
    int                 cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   win [3][8];
  int   wptr, fill;
  logic signed [15:0] want;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  function automatic int floor_avg(int s);
    int q;
    q = s / 8;
    if (s < 0 && (s % 8) != 0) q = q - 1;
    return q;
  endfunction

  function automatic logic tilt_of(int v);
    return ((v < 0) ? -v : v) > 64;
  endfunction

  task automatic model_clear();
    for (int a = 0; a < 3; a++)
      for (int i = 0; i < 8; i++) win[a][i] = 0;
    wptr = 0;
    fill = 0;
    sb.delete();
  endtask

  task automatic model_push(int x, int y, int z);
    exp_t e;
    int   s [3];
    win[0][wptr] = x;
    win[1][wptr] = y;
    win[2][wptr] = z;
    wptr = (wptr + 1) % 8;
    if (fill < 8) fill++;
    if (fill == 8) begin
      for (int a = 0; a < 3; a++) begin
        s[a] = 0;
        for (int i = 0; i < 8; i++) s[a] += win[a][i];
      end
      e.fx  = 16'(floor_avg(s[0]));
      e.fy  = 16'(floor_avg(s[1]));
      e.fz  = 16'(floor_avg(s[2]));
      e.tx  = tilt_of(floor_avg(s[0]));
      e.ty  = tilt_of(floor_avg(s[1]));
      e.tz  = tilt_of(floor_avg(s[2]));
      e.cyc = cyc + 2;
      sb.push_back(e);
    end
  endtask

  // Drives one sample for exactly one rising edge; returns 1 ns after it.
  task automatic drive(int x, int y, int z);
    @(negedge CLOCK_50);
    AccelX       = 16'(x);
    AccelY       = 16'(y);
    AccelZ       = 16'(z);
    SAMPLE_VALID = 1'b1;
    @(posedge CLOCK_50);
    #1;
    SAMPLE_VALID = 1'b0;
  endtask

  task automatic send(int x, int y, int z);
    drive(x, y, z);
    model_push(x, y, z);
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge CLOCK_50);
  endtask

  task automatic send_n(int n, int x, int y, int z, int gap);
    for (int i = 0; i < n; i++) begin
      send(x, y, z);
      idle(gap);
    end
  endtask

  task automatic do_clear(logic with_sample);
    @(negedge CLOCK_50);
    CLEAR        = 1'b1;
    SAMPLE_VALID = with_sample;
    AccelX       = 16'sd500;
    @(posedge CLOCK_50);
    #1;
    CLEAR        = 1'b0;
    SAMPLE_VALID = 1'b0;
    model_clear();
  endtask

  task automatic wait_drain(string name);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d expected FILT_VALID outputs still pending, required 0", name, sb.size());
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (RESET === 1'b0 && FILT_VALID === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_filt_valid: FILT_VALID=1 at cycle %0d, required no output", cyc);
      end else begin
        mon_e = sb.pop_front();
        if (FILT_X !== mon_e.fx || FILT_Y !== mon_e.fy || FILT_Z !== mon_e.fz ||
            TILT_X !== mon_e.tx || TILT_Y !== mon_e.ty || TILT_Z !== mon_e.tz ||
            PRIMED !== 1'b1 || cyc !== mon_e.cyc) begin
          errors++;
          $display("FAIL filt_output: got X=%0d Y=%0d Z=%0d tilt=%b%b%b primed=%b cyc=%0d required X=%0d Y=%0d Z=%0d tilt=%b%b%b primed=1 cyc=%0d",
                   FILT_X, FILT_Y, FILT_Z, TILT_X, TILT_Y, TILT_Z, PRIMED, cyc,
                   mon_e.fx, mon_e.fy, mon_e.fz, mon_e.tx, mon_e.ty, mon_e.tz, mon_e.cyc);
        end
      end
    end
  end

  task automatic check_outputs_zero(string name);
    checks++;
    if ({FILT_X, FILT_Y, FILT_Z} !== 48'd0 || {FILT_VALID, TILT_X, TILT_Y, TILT_Z, PRIMED, OVERRUN} !== 6'd0) begin
      errors++;
      $display("FAIL %s: got X=%0d Y=%0d Z=%0d valid=%b tilt=%b%b%b primed=%b overrun=%b required all 0",
               name, FILT_X, FILT_Y, FILT_Z, FILT_VALID, TILT_X, TILT_Y, TILT_Z, PRIMED, OVERRUN);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    #1;
    check_outputs_zero("reset_async");
    idle(3);
    #1;
    check_outputs_zero("reset_held");
    @(negedge CLOCK_50);
    RESET = 1'b0;
    idle(2);
    #1;
    check_outputs_zero("reset_released");
  endtask

  task automatic test_prime();
    send_n(8, 100, -100, 256, 9);
    wait_drain("prime");
    checks++;
    if (PRIMED !== 1'b1 || FILT_X !== 16'sd100 || FILT_Y !== -16'sd100 || FILT_Z !== 16'sd256 ||
        {TILT_X, TILT_Y, TILT_Z} !== 3'b111) begin
      errors++;
      $display("FAIL prime_final: got primed=%b X=%0d Y=%0d Z=%0d tilt=%b%b%b required primed=1 X=100 Y=-100 Z=256 tilt=111",
               PRIMED, FILT_X, FILT_Y, FILT_Z, TILT_X, TILT_Y, TILT_Z);
    end
  endtask

  task automatic test_sliding();
    do_clear(1'b0);
    send_n(8, 0, 0, 0, 2);
    send_n(4, 80, 0, 0, 2);
    wait_drain("slide_half");
    checks++;
    if (FILT_X !== 16'sd40) begin
      errors++;
      $display("FAIL slide_half: got FILT_X=%0d required 40", FILT_X);
    end
    send_n(4, 80, 0, 0, 2);
    wait_drain("slide_wrap");
    checks++;
    if (FILT_X !== 16'sd80) begin
      errors++;
      $display("FAIL slide_wrap: got FILT_X=%0d required 80", FILT_X);
    end
  endtask

  task automatic test_rounding();
    do_clear(1'b0);
    send(-9, 0, 0);
    idle(2);
    send_n(7, 0, 0, 0, 2);
    wait_drain("floor");
    want = -16'sd2;
    checks++;
    if (FILT_X !== want || TILT_X !== 1'b0) begin
      errors++;
      $display("FAIL floor: got FILT_X=%0d TILT_X=%b required -2 and 0", FILT_X, TILT_X);
    end
    send_n(8, 64, 0, 0, 2);
    wait_drain("thresh_eq");
    checks++;
    if (FILT_X !== 16'sd64 || TILT_X !== 1'b0) begin
      errors++;
      $display("FAIL thresh_eq: got FILT_X=%0d TILT_X=%b required 64 and 0", FILT_X, TILT_X);
    end
    send_n(8, 65, 0, 0, 2);
    wait_drain("thresh_gt");
    checks++;
    if (FILT_X !== 16'sd65 || TILT_X !== 1'b1) begin
      errors++;
      $display("FAIL thresh_gt: got FILT_X=%0d TILT_X=%b required 65 and 1", FILT_X, TILT_X);
    end
  endtask

  task automatic test_extreme();
    do_clear(1'b0);
    send_n(8, -32768, 0, 0, 2);
    wait_drain("extreme_neg");
    want = 16'sh8000;
    checks++;
    if (FILT_X !== want || TILT_X !== 1'b1) begin
      errors++;
      $display("FAIL extreme_neg: got FILT_X=%0d TILT_X=%b required -32768 and 1", FILT_X, TILT_X);
    end
    send_n(8, 32767, 0, 0, 2);
    wait_drain("extreme_pos");
    checks++;
    if (FILT_X !== 16'sd32767 || TILT_X !== 1'b1) begin
      errors++;
      $display("FAIL extreme_pos: got FILT_X=%0d TILT_X=%b required 32767 and 1", FILT_X, TILT_X);
    end
  endtask

  task automatic test_back_to_back();
    do_clear(1'b0);
    send_n(8, 8, 0, 0, 2);
    send(16, 0, 0);
    idle(2);
    send(24, 0, 0);
    wait_drain("b2b");
    checks++;
    if (OVERRUN !== 1'b0 || FILT_X !== 16'sd11) begin
      errors++;
      $display("FAIL b2b_accept: got OVERRUN=%b FILT_X=%0d required 0 and 11", OVERRUN, FILT_X);
    end
  endtask

  task automatic test_overrun();
    send(16, 0, 0);
    drive(1000, 0, 0);
    wait_drain("overrun");
    idle(4);
    checks++;
    if (OVERRUN !== 1'b1 || FILT_X !== 16'sd12) begin
      errors++;
      $display("FAIL overrun: got OVERRUN=%b FILT_X=%0d required 1 and 12", OVERRUN, FILT_X);
    end
  endtask

  task automatic test_clear();
    do_clear(1'b1);
    check_outputs_zero("clear_same_cycle");
    idle(6);
    send_n(7, 40, -40, 0, 2);
    idle(4);
    checks++;
    if (PRIMED !== 1'b0) begin
      errors++;
      $display("FAIL clear_refill7: got PRIMED=%b required 0", PRIMED);
    end
    send(40, -40, 0);
    wait_drain("clear_refill8");
    checks++;
    if (PRIMED !== 1'b1 || FILT_X !== 16'sd40 || FILT_Y !== -16'sd40) begin
      errors++;
      $display("FAIL clear_refill8: got PRIMED=%b X=%0d Y=%0d required 1 40 -40", PRIMED, FILT_X, FILT_Y);
    end
    send(40, -40, 0);
    do_clear(1'b0);
    idle(6);
    check_outputs_zero("clear_in_flight");
  endtask

  task automatic test_reset_mid();
    send_n(8, 300, 0, 0, 2);
    wait_drain("reset_prime");
    send(300, 0, 0);
    RESET = 1'b1;
    #1;
    model_clear();
    check_outputs_zero("reset_in_acc");
    idle(2);
    @(negedge CLOCK_50);
    RESET = 1'b0;
    idle(8);
    #1;
    check_outputs_zero("reset_after");
  endtask

  initial begin
    SAMPLE_VALID = 1'b0;
    CLEAR        = 1'b0;
    AccelX       = '0;
    AccelY       = '0;
    AccelZ       = '0;
    model_clear();
    test_reset();
    test_prime();
    test_sliding();
    test_rounding();
    test_extreme();
    test_back_to_back();
    test_overrun();
    test_clear();
    test_reset_mid();
    wait_drain("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accel_sample_filter.md
Name: accel_sample_filter

Overview:
- Downstream consumer of the ADXL345 I2C reader.
- Takes each completed X/Y/Z sample set (signed 16-bit per axis) plus a one-cycle valid strobe.
- Keeps a per-axis moving average over a 2^LOG2_DEPTH sample window and produces filtered values, a filtered-valid strobe and per-axis tilt flags.
- Those outputs feed LED display and motor control logic.

Parameters:
- LOG2_DEPTH, 3, log2 of averaging window length (window = 8 samples); legal range 1..6.
- TILT_THRESH, 16'd64, unsigned magnitude threshold for tilt flags, in raw accelerometer LSBs.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- RESET  input  1  asynchronous, active-high reset.
- AccelX  input  16  signed two's-complement X sample.
- AccelY  input  16  signed two's-complement Y sample.
- AccelZ  input  16  signed two's-complement Z sample.
- SAMPLE_VALID  input  1  one-cycle pulse; AccelX/Y/Z are stable and valid in this cycle.
- CLEAR  input  1  synchronous flush of window contents.
- FILT_X  output  16  signed averaged X.
- FILT_Y  output  16  signed averaged Y.
- FILT_Z  output  16  signed averaged Z.
- FILT_VALID  output  1  one-cycle pulse; FILT_* updated.
- TILT_X  output  1  |FILT_X| > TILT_THRESH.
- TILT_Y  output  1  |FILT_Y| > TILT_THRESH.
- TILT_Z  output  1  |FILT_Z| > TILT_THRESH.
- PRIMED  output  1  window has been completely filled since last reset/CLEAR.
- OVERRUN  output  1  sticky; a sample was dropped because the block was busy.

Behaviour:
- Reset (RESET high, async): all outputs 0; ring buffer entries, running sums, write pointer and fill counter all 0; FSM to IDLE.
- Storage: per-axis ring buffer of 2^LOG2_DEPTH x 16-bit entries, one shared write pointer (wraps from 2^LOG2_DEPTH-1 to 0).
- Running sums: per-axis signed accumulator of width 16+LOG2_DEPTH; never overflows by construction.
- FSM states:
  - IDLE: on SAMPLE_VALID, latch AccelX/Y/Z, go to ACC.
  - ACC: for each axis, sum <= sum + new - buf[wr_ptr]; buf[wr_ptr] <= new; wr_ptr++; fill counter increments, saturating at 2^LOG2_DEPTH. Go to OUT.
  - OUT: if the fill counter equals 2^LOG2_DEPTH, set FILT_* = sum >>> LOG2_DEPTH (arithmetic shift, floor toward negative infinity), update TILT_*, and pulse FILT_VALID. Otherwise, hold outputs. Go to IDLE.
- Latency: SAMPLE_VALID sampled at edge N; FILT_VALID high in the cycle after edge N+2.
  - A new SAMPLE_VALID may be accepted in that same FILT_VALID cycle (FSM is back in IDLE).
  - Maximum sustained rate: one sample per 3 clocks.
- PRIMED: asserted in the same cycle as the first FILT_VALID after fill; stays high until RESET or CLEAR.
  - No FILT_VALID is produced before PRIMED; the first 2^LOG2_DEPTH-1 samples only load the window.
- Tilt magnitude: |v| computed in 17 bits, so -32768 yields 32768, with no wrap. Compare is strictly greater-than; equality gives flag 0.
- TILT_* and FILT_* update only together with FILT_VALID and otherwise hold.
- Overrun: SAMPLE_VALID arriving while the FSM is in ACC or OUT is ignored (sample dropped, FSM undisturbed) and OVERRUN is set to 1. OVERRUN clears only on RESET or CLEAR.
- CLEAR (synchronous, at the next edge):
  - Zeroes buffer, sums, pointer, fill counter, PRIMED, OVERRUN and TILT_*; FILT_* also go to 0.
  - FSM returns to IDLE.
  - Any sample in flight is abandoned with no FILT_VALID.
  - CLEAR has priority over a simultaneous SAMPLE_VALID, which is dropped without setting OVERRUN.
- RESET asserted mid-operation: immediate return to the reset state; no partial FILT_VALID.

Test Plan:
- Prime: 8 samples X=100, Y=-100, Z=256, spaced 10 clocks -> no FILT_VALID for samples 1-7. On sample 8: FILT_VALID exactly 3 cycles after the SAMPLE_VALID edge, FILT_X=100, FILT_Y=-100, FILT_Z=256; PRIMED=1; TILT_X=1, TILT_Y=1, TILT_Z=1.
- Sliding window and wrap: after priming with X=0 x8, feed X=80 x4 -> FILT_X=10, 20, 30, 40. Feed 4 more X=80 -> FILT_X=80 (pointer has wrapped).
- Rounding and threshold: window sum for X = -9 (seven 0s, one -9) -> FILT_X=-2 (floor). Window of all X=64 -> TILT_X=0; all X=65 -> TILT_X=1.
- Extreme: prime with X=-32768 x8 -> FILT_X=-32768, TILT_X=1, no wrap. Then X=32767 x8 -> FILT_X=32767.
- Overrun: SAMPLE_VALID on 2 consecutive clocks -> second sample ignored, OVERRUN=1, window advances by one sample only. SAMPLE_VALID in the FILT_VALID cycle -> accepted, OVERRUN unchanged.
- CLEAR/RESET: CLEAR and SAMPLE_VALID in the same cycle after priming -> PRIMED=0, OVERRUN=0, FILT_*=0, no FILT_VALID; 8 fresh samples are needed before the next FILT_VALID. RESET pulsed in the ACC state -> all outputs 0 immediately, no FILT_VALID.
